// File: rtl/decoder_serial_framer_pkg.sv
// Shared definitions for the decoder serial framer: codeword width and FSM state encoding.
package decoder_serial_framer_pkg;

  localparam int DEC_WORD_W = 7;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } fsm_state_t;

endpackage

// File: rtl/decoder_serial_framer_pad_sync.sv
// Multi-flop synchronizer for one asynchronous pad input, with a selectable reset value.
module decoder_serial_framer_pad_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_r;

  // Shift the pad value through the synchronizer chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= {STAGES{RST_VAL}};
    end else begin
      sync_r <= {sync_r[STAGES-2:0], d};
    end
  end

  assign q = sync_r[STAGES-1];

endmodule

// File: rtl/decoder_serial_framer.sv
// Serial (sclk/cs_n/sdi) to parallel codeword framer with a small buffer and a
// registered valid/ready output toward the decoder.
module decoder_serial_framer
  import decoder_serial_framer_pkg::*;
#(
  parameter int WORD_W      = DEC_WORD_W,
  parameter int FIFO_DEPTH  = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              ser_sclk_i,
  input  logic              ser_csn_i,
  input  logic              ser_sdi_i,
  output logic [WORD_W-1:0] word_o,
  output logic              word_valid_o,
  input  logic              word_ready_i,
  output logic              frame_err_o,
  output logic              ovf_o,
  input  logic              ovf_clr_i
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int PTR_W = AW + 1;
  localparam int CNT_W = $clog2(WORD_W + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORD_W);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WORD_W + 1);

  logic sclk_s, csn_s, sdi_s;
  logic sclk_prev_r, csn_prev_r, armed_r;
  logic [SYNC_STAGES-1:0] warm_r;
  logic sclk_rise_s, csn_rise_s, csn_fall_s;

  fsm_state_t state_r, state_nx;
  logic [WORD_W-1:0] shift_r, shift_nx;
  logic [CNT_W-1:0]  cnt_r, cnt_nx;
  logic close_ok_s, close_err_s;
  logic push_r, err_r, ovf_r;
  logic [WORD_W-1:0] push_data_r;

  logic [WORD_W-1:0] mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]  wptr_r, rptr_r, wptr_nx, rptr_nx;
  logic [AW-1:0]     rd_idx_s;
  logic [WORD_W-1:0] word_r, word_nx;
  logic valid_r, valid_nx;
  logic full_s, pop_s, wr_s, drop_s;

  decoder_serial_framer_pad_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(wb_clk_i), .rst(wb_rst_i), .d(ser_sclk_i), .q(sclk_s));
  decoder_serial_framer_pad_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_csn (
    .clk(wb_clk_i), .rst(wb_rst_i), .d(ser_csn_i), .q(csn_s));
  decoder_serial_framer_pad_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdi (
    .clk(wb_clk_i), .rst(wb_rst_i), .d(ser_sdi_i), .q(sdi_s));

  // A falling csn only opens a frame once csn has been seen high with real
  // (post-reset) synchronizer contents, so a frame already in flight is ignored.
  assign sclk_rise_s = sclk_s & ~sclk_prev_r;
  assign csn_rise_s  = csn_s & ~csn_prev_r;
  assign csn_fall_s  = ~csn_s & csn_prev_r & armed_r;

  // Next-state and shift/count logic of the framing FSM.
  always_comb begin
    state_nx    = state_r;
    shift_nx    = shift_r;
    cnt_nx      = cnt_r;
    close_ok_s  = 1'b0;
    close_err_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (csn_fall_s) begin
          state_nx = ST_SHIFT;
          shift_nx = {WORD_W{1'b0}};
          cnt_nx   = {CNT_W{1'b0}};
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (sclk_rise_s) begin
          shift_nx = {shift_r[WORD_W-2:0], sdi_s};
          if (cnt_r != CNT_SAT) begin
            cnt_nx = cnt_r + CNT_W'(1);
          end else begin
            cnt_nx = cnt_r;
          end
        end else begin
          shift_nx = shift_r;
        end
        if (csn_rise_s) begin
          state_nx = ST_IDLE;
          if (cnt_nx == CNT_FULL) begin
            close_ok_s = 1'b1;
          end else begin
            close_err_s = 1'b1;
          end
        end else begin
          state_nx = ST_SHIFT;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Framing state, edge history and the registered push/error requests.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_r     <= ST_IDLE;
      shift_r     <= {WORD_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      sclk_prev_r <= 1'b0;
      csn_prev_r  <= 1'b1;
      armed_r     <= 1'b0;
      warm_r      <= {SYNC_STAGES{1'b0}};
      push_r      <= 1'b0;
      push_data_r <= {WORD_W{1'b0}};
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_nx;
      shift_r     <= shift_nx;
      cnt_r       <= cnt_nx;
      sclk_prev_r <= sclk_s;
      csn_prev_r  <= csn_s;
      armed_r     <= armed_r | (warm_r[SYNC_STAGES-1] & csn_s);
      warm_r      <= {warm_r[SYNC_STAGES-2:0], 1'b1};
      push_r      <= close_ok_s;
      push_data_r <= shift_nx;
      err_r       <= close_err_s;
    end
  end

  // word_o/word_valid_o are loaded from the next-cycle FIFO head, so the
  // output register is part of the buffer rather than an extra slot.
  always_comb begin
    full_s   = (wptr_r[AW] != rptr_r[AW]) && (wptr_r[AW-1:0] == rptr_r[AW-1:0]);
    pop_s    = valid_r & word_ready_i;
    wr_s     = push_r & (~full_s | pop_s);
    drop_s   = push_r & full_s & ~pop_s;
    wptr_nx  = wptr_r + {{(PTR_W-1){1'b0}}, wr_s};
    rptr_nx  = rptr_r + {{(PTR_W-1){1'b0}}, pop_s};
    rd_idx_s = rptr_nx[AW-1:0];
    valid_nx = (wptr_nx != rptr_nx);
    if (wr_s && (wptr_r[AW-1:0] == rd_idx_s)) begin
      word_nx = push_data_r;
    end else begin
      word_nx = mem_r[rd_idx_s];
    end
  end

  // Buffer storage.
  always_ff @(posedge wb_clk_i) begin
    if (wr_s) begin
      mem_r[wptr_r[AW-1:0]] <= push_data_r;
    end
  end

  // Buffer pointers, registered output stage and sticky overflow.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wptr_r  <= {PTR_W{1'b0}};
      rptr_r  <= {PTR_W{1'b0}};
      word_r  <= {WORD_W{1'b0}};
      valid_r <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      wptr_r  <= wptr_nx;
      rptr_r  <= rptr_nx;
      word_r  <= word_nx;
      valid_r <= valid_nx;
      if (drop_s) begin
        ovf_r <= 1'b1;
      end else if (ovf_clr_i) begin
        ovf_r <= 1'b0;
      end
    end
  end

  assign word_o       = word_r;
  assign word_valid_o = valid_r;
  assign frame_err_o  = err_r;
  assign ovf_o        = ovf_r;

endmodule

// File: tb/tb_decoder_serial_framer.sv
// Directed bench for decoder_serial_framer: scoreboard of expected codewords,
// monitor comparing every transfer and output stability while stalled.
module tb_decoder_serial_framer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclk = 1'b0;
  logic       csn = 1'b1;
  logic       sdi = 1'b0;
  logic [6:0] word;
  logic       valid;
  logic       ready = 1'b0;
  logic       ready_cmd = 1'b0;
  logic       toggle_en = 1'b0;
  logic       ferr;
  logic       ovf;
  logic       ovf_clr = 1'b0;

  int checks = 0;
  int errors = 0;
  int xfer_cnt = 0;
  int err_cnt = 0;
  logic [6:0] exp_q [$];

  logic       prev_valid = 1'b0;
  logic       prev_ready = 1'b0;
  logic [6:0] prev_word = 7'd0;

  decoder_serial_framer dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .ser_sclk_i  (sclk),
    .ser_csn_i   (csn),
    .ser_sdi_i   (sdi),
    .word_o      (word),
    .word_valid_o(valid),
    .word_ready_i(ready),
    .frame_err_o (ferr),
    .ovf_o       (ovf),
    .ovf_clr_i   (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ready driver: fixed level or toggling every cycle
  always @(negedge clk) begin
    if (toggle_en) ready = ~ready;
    else ready = ready_cmd;
  end

  // transfer monitor / scoreboard
  always @(negedge clk) begin
    #2;
    if (prev_valid && !prev_ready) begin
      check("stall_valid", {31'd0, valid}, 32'd1);
      check("stall_word", {25'd0, word}, {25'd0, prev_word});
    end
    if (ferr) err_cnt++;
    if (valid && ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL xfer_extra: observed %0h expected no transfer", word);
      end else begin
        check("xfer_word", {25'd0, word}, {25'd0, exp_q.pop_front()});
      end
      xfer_cnt++;
    end
    prev_valid = valid;
    prev_ready = ready;
    prev_word  = word;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] data, input int n);
    for (int i = 0; i < n; i++) begin
      sdi = data[n-1-i];
      cyc(4);
      sclk = 1'b1;
      cyc(4);
      sclk = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [7:0] data, input int n);
    csn = 1'b0;
    cyc(4);
    send_bits(data, n);
    cyc(4);
    csn = 1'b1;
    cyc(6);
  endtask

  task automatic wait_xfers(input int target, input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      if (xfer_cnt >= target) break;
      @(negedge clk);
      #3;
    end
    check(tag, xfer_cnt, target);
  endtask

  initial begin
    int base_err;
    // reset state
    rst = 1'b1;
    cyc(2);
    #3;
    check("rst_word", {25'd0, word}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_ferr", {31'd0, ferr}, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);
    // frame sent while reset is held is ignored
    send_frame(8'b0101_0011, 7);
    rst = 1'b0;
    cyc(20);
    check("rst_frame_xfers", xfer_cnt, 0);
    check("rst_frame_valid", {31'd0, valid}, 32'd0);

    // single frame with ready high
    ready_cmd = 1'b1;
    exp_q.push_back(7'b1100000);
    send_frame(8'b0110_0000, 7);
    wait_xfers(1, 40, "single_xfer");
    @(negedge clk);
    #3;
    check("valid_drop", {31'd0, valid}, 32'd0);
    check("single_ovf", {31'd0, ovf}, 32'd0);

    // three frames into a full buffer, third dropped
    ready_cmd = 1'b0;
    exp_q.push_back(7'b0000001);
    exp_q.push_back(7'b1010101);
    send_frame(8'b0000_0001, 7);
    send_frame(8'b0101_0101, 7);
    send_frame(8'b0111_1111, 7);
    cyc(10);
    #3;
    check("ovf_set", {31'd0, ovf}, 32'd1);
    check("full_head", {25'd0, word}, 32'h01);
    ready_cmd = 1'b1;
    wait_xfers(3, 40, "ovf_xfers");
    cyc(10);
    check("ovf_no_third", xfer_cnt, 3);
    check("ovf_sticky", {31'd0, ovf}, 32'd1);
    ovf_clr = 1'b1;
    cyc(1);
    ovf_clr = 1'b0;
    #3;
    check("ovf_clear", {31'd0, ovf}, 32'd0);

    // short and long frames raise frame_err only
    base_err = err_cnt;
    send_frame(8'b0010_1101, 6);
    cyc(4);
    check("err6_pulse", err_cnt, base_err + 1);
    send_frame(8'b1011_0110, 8);
    cyc(4);
    check("err8_pulse", err_cnt, base_err + 2);
    check("err_no_word", xfer_cnt, 3);
    exp_q.push_back(7'b0101010);
    send_frame(8'b0010_1010, 7);
    wait_xfers(4, 40, "after_err_xfer");
    check("after_err_ferr", err_cnt, base_err + 2);

    // reset in the middle of a frame
    base_err = err_cnt;
    csn = 1'b0;
    cyc(4);
    send_bits(8'b0000_1011, 4);
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    send_bits(8'b0000_0101, 3);
    cyc(4);
    csn = 1'b1;
    cyc(20);
    check("midrst_xfers", xfer_cnt, 4);
    check("midrst_err", err_cnt, base_err);
    exp_q.push_back(7'b0011100);
    send_frame(8'b0001_1100, 7);
    wait_xfers(5, 40, "midrst_next_xfer");

    // back-to-back frames with ready toggling every cycle
    toggle_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      logic [6:0] w;
      w = 7'($urandom_range(0, 127));
      exp_q.push_back(w);
      send_frame({1'b0, w}, 7);
    end
    wait_xfers(10, 60, "toggle_xfers");
    toggle_en = 1'b0;
    ready_cmd = 1'b0;
    cyc(10);
    check("toggle_ovf", {31'd0, ovf}, 32'd0);
    check("toggle_queue_empty", exp_q.size(), 0);
    check("final_xfers", xfer_cnt, 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
